// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
// Used by wb_fifo and regfile_write_arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t address;
    word_t     data;
  } wb_req_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } requester_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input reg_addr_t a
  );
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small writeback request FIFO with per-slot visibility
// so the owner can build a pending-register mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output wb_req_t          head,
  output wb_req_t          entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head        = mem[rd_ptr[PW-1:0]];
  assign entries     = mem;
  assign entry_valid = vld;

  // Pointers, storage and slot-valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        rd_ptr                <= rd_ptr + 1'b1;
        vld[rd_ptr[PW-1:0]]   <= 1'b0;
      end
      if (do_push) begin
        wr_ptr                <= wr_ptr + 1'b1;
        mem[wr_ptr[PW-1:0]]   <= push_data;
        vld[wr_ptr[PW-1:0]]   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one RF write port.
// Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin, else B wins.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_write_enable,
  output logic [DATA_W-1:0] rd_write_data,
  output logic [31:0]       pending_mask,
  output logic              idle
);

  wb_req_t          a_req;
  wb_req_t          b_req;
  logic             a_full;
  logic             a_empty;
  logic             b_full;
  logic             b_empty;
  wb_req_t          a_head;
  wb_req_t          b_head;
  wb_req_t          a_ent [DEPTH];
  wb_req_t          b_ent [DEPTH];
  logic [DEPTH-1:0] a_ev;
  logic [DEPTH-1:0] b_ev;
  logic             a_push;
  logic             b_push;
  logic             pop_a;
  logic             pop_b;
  logic             contended;
  wb_req_t          grant_req;
  wb_req_t          out_q;
  logic             we_q;

  assign a_req = '{address: reg_addr_t'(a_address),
                   data:    word_t'(a_data)};
  assign b_req = '{address: reg_addr_t'(b_address),
                   data:    word_t'(b_data)};

  assign a_ready = !a_full;
  assign b_ready = !b_full;

  // x0 writes complete the handshake but are never queued.
  assign a_push = a_valid && !a_full && (a_req.address != '0);
  assign b_push = b_valid && !b_full && (b_req.address != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk        (clock),
    .rst_n      (n_reset),
    .push       (a_push),
    .push_data  (a_req),
    .pop        (pop_a),
    .full       (a_full),
    .empty      (a_empty),
    .head       (a_head),
    .entries    (a_ent),
    .entry_valid(a_ev)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk        (clock),
    .rst_n      (n_reset),
    .push       (b_push),
    .push_data  (b_req),
    .pop        (pop_b),
    .full       (b_full),
    .empty      (b_empty),
    .head       (b_head),
    .entries    (b_ent),
    .entry_valid(b_ev)
  );

  assign contended = !a_empty && !b_empty;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  requester_e rr_q;

  // Priority pointer flips only after a contended grant.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rr_q <= REQ_A;
    end else if (contended) begin
      rr_q <= (rr_q == REQ_A) ? REQ_B : REQ_A;
    end
  end
`endif

  // Pick at most one non-empty head per cycle.
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    unique case (1'b1)
      (a_empty && b_empty): begin
      end
      (!a_empty && b_empty): pop_a = 1'b1;
      (a_empty && !b_empty): pop_b = 1'b1;
      contended: begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        pop_a = (rr_q == REQ_A);
        pop_b = (rr_q == REQ_B);
`else
        pop_b = 1'b1;
`endif
      end
    endcase
  end

  assign grant_req = pop_b ? b_head : a_head;

  // Registered write port: one cycle of enable per pop.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q <= pop_a || pop_b;
      if (pop_a || pop_b) begin
        out_q <= grant_req;
      end
    end
  end

  assign rd_write_enable = we_q;
  assign rd_address      = ADDR_W'(out_q.address);
  assign rd_write_data   = DATA_W'(out_q.data);

  // Every accepted but unretired destination register.
  always_comb begin
    pending_mask = we_q ? reg_onehot(out_q.address) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ev[i]) pending_mask |= reg_onehot(a_ent[i].address);
      if (b_ev[i]) pending_mask |= reg_onehot(b_ent[i].address);
    end
  end

  assign idle = a_empty && b_empty && !we_q;

`ifndef SYNTHESIS
  a_no_hazard: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(a_push && pending_mask[a_req.address]));

  b_no_hazard: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(b_push && pending_mask[b_req.address]));

  ab_no_clash: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(a_push && b_push && a_req.address == b_req.address));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a
// per-requester scoreboard and a pending-mask model.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_address;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_address;
  logic [31:0] b_data;
  logic [4:0]  rd_address;
  logic        rd_write_enable;
  logic [31:0] rd_write_data;
  logic [31:0] pending_mask;
  logic        idle;

  int          vectors = 0;
  int          miscompares = 0;
  logic [36:0] exp_a [$];
  logic [36:0] exp_b [$];
  logic [4:0]  order [$];
  int          when [$];
  int          cyc = 0;
  int          writes = 0;
  logic [36:0] mon_obs;
  bit          mon_hit;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .DEPTH (2),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clock          (clock),
    .n_reset        (n_reset),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_address      (a_address),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_address      (b_address),
    .b_data         (b_data),
    .rd_address     (rd_address),
    .rd_write_enable(rd_write_enable),
    .rd_write_data  (rd_write_data),
    .pending_mask   (pending_mask),
    .idle           (idle)
  );

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (exp_a[i]) m[exp_a[i][36:32]] = 1'b1;
    foreach (exp_b[i]) m[exp_b[i][36:32]] = 1'b1;
    return m;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Retire each observed write against the scoreboard heads.
  always @(negedge clock) begin
    if (n_reset && rd_write_enable) begin
      mon_obs = {rd_address, rd_write_data};
      mon_hit = 1'b0;
      if (exp_a.size() > 0 && exp_a[0] === mon_obs) begin
        void'(exp_a.pop_front());
        mon_hit = 1'b1;
      end else if (exp_b.size() > 0 && exp_b[0] === mon_obs) begin
        void'(exp_b.pop_front());
        mon_hit = 1'b1;
      end
      check("wb_match", 64'(mon_hit), 64'd1);
      writes++;
      order.push_back(rd_address);
      when.push_back(cyc);
    end
  end

  task automatic cycle(output bit acc_a, output bit acc_b);
    @(negedge clock);
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    if (acc_a && a_address != 5'd0)
      exp_a.push_back({a_address, a_data});
    if (acc_b && b_address != 5'd0)
      exp_b.push_back({b_address, b_data});
    @(posedge clock);
    #1;
    check("pending_mask", 64'(pending_mask), 64'(model_mask()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   aa, bb, sa, sb;
    int   ai, bi, w0, n;
    logic [4:0] ea;

    n_reset   = 1'b0;
    a_valid   = 1'b0;
    a_address = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_address = '0;
    b_data    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_we",   64'(rd_write_enable), 64'd0);
    check("rst_addr", 64'(rd_address), 64'd0);
    check("rst_data", 64'(rd_write_data), 64'd0);
    check("rst_mask", 64'(pending_mask), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ardy", 64'(a_ready), 64'd1);
    check("rst_brdy", 64'(b_ready), 64'd1);
    n_reset = 1'b1;
    cycle(aa, bb);

    a_valid   = 1'b1;
    a_address = 5'd5;
    a_data    = 32'hDEADBEEF;
    cycle(aa, bb);
    check("t2_acc", 64'(aa), 64'd1);
    a_valid = 1'b0;
    check("t2_mask", 64'(pending_mask), 64'h20);
    check("t2_we0", 64'(rd_write_enable), 64'd0);
    check("t2_idle0", 64'(idle), 64'd0);
    cycle(aa, bb);
    check("t2_we1", 64'(rd_write_enable), 64'd1);
    check("t2_addr", 64'(rd_address), 64'd5);
    check("t2_data", 64'(rd_write_data), 64'hDEADBEEF);
    check("t2_mask1", 64'(pending_mask), 64'h20);
    cycle(aa, bb);
    check("t2_we2", 64'(rd_write_enable), 64'd0);
    check("t2_mask2", 64'(pending_mask), 64'd0);
    check("t2_idle", 64'(idle), 64'd1);

    a_valid   = 1'b1;
    a_address = 5'd0;
    a_data    = 32'h1234;
    w0        = writes;
    cycle(aa, bb);
    check("x0_hs", 64'(aa), 64'd1);
    a_valid = 1'b0;
    repeat (3) cycle(aa, bb);
    check("x0_nowr", 64'(writes), 64'(w0));
    check("x0_mask", 64'(pending_mask), 64'd0);

    ai = 0;
    bi = 0;
    sa = 1'b0;
    sb = 1'b0;
    w0 = order.size();
    for (int k = 0; k < 100 && (ai < 8 || bi < 8); k++) begin
      a_valid   = (ai < 8);
      a_address = 5'(ai + 1);
      a_data    = 32'hA0000000 + 32'(ai);
      b_valid   = (bi < 8);
      b_address = 5'(bi + 9);
      b_data    = 32'hB0000000 + 32'(bi);
      cycle(aa, bb);
      if (aa) ai++;
      if (bb) bi++;
      if (!a_ready) sa = 1'b1;
      if (!b_ready) sb = 1'b1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t3_asent", 64'(ai), 64'd8);
    check("t3_bsent", 64'(bi), 64'd8);
    for (int k = 0; k < 40 && !idle; k++) cycle(aa, bb);
    check("t3_idle", 64'(idle), 64'd1);
    n = order.size() - w0;
    check("t3_writes", 64'(n), 64'd16);
    check("t3_sb", 64'(exp_a.size() + exp_b.size()), 64'd0);
    if (n == 16) begin
      for (int i = 0; i < 16; i++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        ea = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(9 + i / 2);
`else
        ea = (i < 8) ? 5'(9 + i) : 5'(1 + i - 8);
`endif
        check("t3_grant", 64'(order[w0 + i]), 64'(ea));
      end
      check("t3_rate", 64'(when[w0 + 15] - when[w0]), 64'd15);
    end
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    check("t4_bfull", 64'(sb), 64'd1);
`else
    check("t4_afull", 64'(sa), 64'd1);
    check("t4_bnever", 64'(sb), 64'd0);
`endif

    a_valid   = 1'b1;
    a_address = 5'd20;
    a_data    = 32'h1;
    b_valid   = 1'b1;
    b_address = 5'd21;
    b_data    = 32'h2;
    cycle(aa, bb);
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t1_aacc", 64'(aa), 64'd1);
    check("t1_bacc", 64'(bb), 64'd1);
    @(negedge clock);
    n_reset = 1'b0;
    #1;
    check("t1_we", 64'(rd_write_enable), 64'd0);
    check("t1_mask", 64'(pending_mask), 64'd0);
    check("t1_ardy", 64'(a_ready), 64'd1);
    check("t1_brdy", 64'(b_ready), 64'd1);
    check("t1_idle", 64'(idle), 64'd1);
    exp_a.delete();
    exp_b.delete();
    w0 = writes;
    repeat (2) @(posedge clock);
    #1;
    n_reset = 1'b1;
    repeat (4) cycle(aa, bb);
    check("t1_nowr", 64'(writes), 64'(w0));
    check("t1_idle2", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
